// File: rtl/sys_bus_pkg.sv
// Shared definitions for the register-domain slave demultiplexer:
// bus widths, the error read-data pattern and the transaction state encoding.
package sys_bus_pkg;

   localparam int AW = 32;
   localparam int DW = 32;

   localparam logic [DW-1:0] SYS_BUS_ERR_DATA = 32'hDEADBEEF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_STRB = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } bus_state_e;

endpackage

// File: rtl/sys_bus_wdog.sv
// Slave-response watchdog: counts cycles spent waiting for a slave ack and
// flags expiry once TMO-1 unanswered cycles have been counted.
module sys_bus_wdog #(
   parameter int TMO = 256
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic clr_i,
   input  logic inc_i,
   output logic expire_o
);
   localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;

   logic [CW-1:0] r_cnt;

   // wait-cycle counter; clear dominates increment
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_cnt <= '0;
      end else if (clr_i) begin
         r_cnt <= '0;
      end else if (inc_i) begin
         r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign expire_o = (r_cnt == CW'(TMO - 1));

endmodule

// File: rtl/sys_bus_slave_demux.sv
// Register-domain address decoder: one request in flight, strobed to the slave
// selected by address bits, answered by exactly one s_ack_o pulse.
module sys_bus_slave_demux
   import sys_bus_pkg::*;
#(
   parameter int SN  = 8,
   parameter int SW  = 20,
   parameter int TMO = 256
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic [AW-1:0]    s_addr_i,
   input  logic [DW-1:0]    s_wdata_i,
   input  logic             s_wen_i,
   input  logic             s_ren_i,
   output logic [DW-1:0]    s_rdata_o,
   output logic             s_ack_o,
   output logic             s_err_o,
   output logic [AW-1:0]    m_addr_o,
   output logic [DW-1:0]    m_wdata_o,
   output logic [SN-1:0]    m_wen_o,
   output logic [SN-1:0]    m_ren_o,
   input  logic [SN*DW-1:0] m_rdata_i,
   input  logic [SN-1:0]    m_ack_i,
   input  logic [SN-1:0]    m_err_i,
   output logic             drop_o
);
   localparam int IW = $clog2(SN);

   bus_state_e    r_state;
   bus_state_e    w_state_nxt;
   logic [IW-1:0] r_idx;
   logic          r_is_wr;
   logic [AW-1:0] r_m_addr;
   logic [DW-1:0] r_m_wdata;
   logic [SN-1:0] r_m_wen;
   logic [SN-1:0] r_m_ren;
   logic          r_s_ack;
   logic          r_s_err;
   logic [DW-1:0] r_s_rdata;
   logic          r_drop;

   logic          w_req;
   logic          w_accept;
   logic [IW-1:0] w_req_idx;
   logic          w_req_bad;
   logic [SN-1:0] w_onehot;
   logic          w_sel_ack;
   logic          w_sel_err;
   logic [DW-1:0] w_sel_rdata;
   logic          w_wdog_clr;
   logic          w_wdog_inc;
   logic          w_wdog_exp;
   logic          w_load_resp;
   logic          w_resp_err;
   logic [DW-1:0] w_resp_data;

   assign w_req       = s_wen_i | s_ren_i;
   assign w_accept    = (r_state == ST_IDLE) & w_req;
   assign w_req_idx   = s_addr_i[SW +: IW];
   assign w_req_bad   = (int'(w_req_idx) >= SN);
   assign w_onehot    = {{(SN-1){1'b0}}, 1'b1} << w_req_idx;
   assign w_sel_ack   = m_ack_i[r_idx];
   assign w_sel_err   = m_err_i[r_idx];
   assign w_sel_rdata = m_rdata_i[DW*r_idx +: DW];

   sys_bus_wdog #(.TMO(TMO)) u_wdog (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .clr_i    (w_wdog_clr),
      .inc_i    (w_wdog_inc),
      .expire_o (w_wdog_exp)
   );

   // state register
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next state and response selection; a same-cycle ack beats the watchdog
   always_comb begin
      w_state_nxt = r_state;
      w_load_resp = 1'b0;
      w_resp_err  = 1'b0;
      w_resp_data = '0;
      w_wdog_clr  = 1'b0;
      w_wdog_inc  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_wdog_clr = 1'b1;
            if (w_req && w_req_bad) begin
               w_state_nxt = ST_RESP;
               w_load_resp = 1'b1;
               w_resp_err  = 1'b1;
               w_resp_data = SYS_BUS_ERR_DATA;
            end else if (w_req) begin
               w_state_nxt = ST_STRB;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_STRB, ST_WAIT: begin
            if (w_sel_ack) begin
               w_state_nxt = ST_RESP;
               w_load_resp = 1'b1;
               w_resp_err  = w_sel_err;
               w_resp_data = r_is_wr ? '0 : w_sel_rdata;
            end else if (w_wdog_exp) begin
               w_state_nxt = ST_RESP;
               w_load_resp = 1'b1;
               w_resp_err  = 1'b1;
               w_resp_data = SYS_BUS_ERR_DATA;
            end else begin
               w_state_nxt = ST_WAIT;
               w_wdog_inc  = 1'b1;
            end
         end
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // request capture, one-cycle strobes, response and sticky drop registers
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_idx     <= '0;
         r_is_wr   <= 1'b0;
         r_m_addr  <= '0;
         r_m_wdata <= '0;
         r_m_wen   <= '0;
         r_m_ren   <= '0;
         r_s_ack   <= 1'b0;
         r_s_err   <= 1'b0;
         r_s_rdata <= '0;
         r_drop    <= 1'b0;
      end else begin
         r_m_wen   <= '0;
         r_m_ren   <= '0;
         r_s_ack   <= w_load_resp;
         r_s_err   <= w_load_resp & w_resp_err;
         r_s_rdata <= w_load_resp ? w_resp_data : '0;
         if (w_accept) begin
            r_idx     <= w_req_idx;
            r_is_wr   <= s_wen_i;
            r_m_addr  <= s_addr_i;
            r_m_wdata <= s_wdata_i;
            if (!w_req_bad && s_wen_i) begin
               r_m_wen <= w_onehot;
            end else if (!w_req_bad) begin
               r_m_ren <= w_onehot;
            end
         end
         if ((r_state != ST_IDLE) && w_req) begin
            r_drop <= 1'b1;
         end
      end
   end

   assign s_rdata_o = r_s_rdata;
   assign s_ack_o   = r_s_ack;
   assign s_err_o   = r_s_err;
   assign m_addr_o  = r_m_addr;
   assign m_wdata_o = r_m_wdata;
   assign m_wen_o   = r_m_wen;
   assign m_ren_o   = r_m_ren;
   assign drop_o    = r_drop;

endmodule

// File: tb/tb_sys_bus_slave_demux.sv
// Self-checking bench: directed scenarios plus randomized transactions compared
// against a transaction-level latency/response model of the demultiplexer.
module tb_sys_bus_slave_demux;

   localparam int TMO_A = 16;
   localparam int TMO_B = 8;

   logic         clk;
   logic         rstn;

   logic [31:0]  a_addr, a_wdata, a_rdata_o, a_m_addr, a_m_wdata;
   logic         a_wen, a_ren, a_ack_o, a_err_o, a_drop;
   logic [7:0]   a_m_wen, a_m_ren, a_m_ack, a_m_err;
   logic [255:0] a_m_rdata;

   logic [31:0]  b_addr, b_wdata, b_rdata_o, b_m_addr, b_m_wdata;
   logic         b_wen, b_ren, b_ack_o, b_err_o, b_drop;
   logic [5:0]   b_m_wen, b_m_ren, b_m_ack, b_m_err;
   logic [191:0] b_m_rdata;

   int n_checks = 0;
   int n_errors = 0;

   sys_bus_slave_demux #(.SN(8), .SW(20), .TMO(TMO_A)) u_dut (
      .clk_i(clk), .rstn_i(rstn),
      .s_addr_i(a_addr), .s_wdata_i(a_wdata), .s_wen_i(a_wen), .s_ren_i(a_ren),
      .s_rdata_o(a_rdata_o), .s_ack_o(a_ack_o), .s_err_o(a_err_o),
      .m_addr_o(a_m_addr), .m_wdata_o(a_m_wdata), .m_wen_o(a_m_wen), .m_ren_o(a_m_ren),
      .m_rdata_i(a_m_rdata), .m_ack_i(a_m_ack), .m_err_i(a_m_err), .drop_o(a_drop)
   );

   sys_bus_slave_demux #(.SN(6), .SW(20), .TMO(TMO_B)) u_dut6 (
      .clk_i(clk), .rstn_i(rstn),
      .s_addr_i(b_addr), .s_wdata_i(b_wdata), .s_wen_i(b_wen), .s_ren_i(b_ren),
      .s_rdata_o(b_rdata_o), .s_ack_o(b_ack_o), .s_err_o(b_err_o),
      .m_addr_o(b_m_addr), .m_wdata_o(b_m_wdata), .m_wen_o(b_m_wen), .m_ren_o(b_m_ren),
      .m_rdata_i(b_m_rdata), .m_ack_i(b_m_ack), .m_err_i(b_m_err), .drop_o(b_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One request on the SN=8 instance. dly = cycles after the strobe cycle at
   // which the selected slave acks (-1: never). Expected response cycle comes
   // from the latency rules: ack at dly <= TMO-1 answers at dly+1, else TMO.
   task automatic run_txn(input bit wr, input bit both, input logic [31:0] addr,
                          input logic [31:0] wdata, input int dly, input logic [31:0] rd,
                          input bit serr, input bit inject);
      int          idx;
      logic [7:0]  sel;
      int          c_exp;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          n_ack;
      int          c_seen;
      int          n_stray;
      logic [31:0] rd_seen;
      logic        err_seen;
      bit          eff_wr;
      eff_wr = wr | both;
      idx = int'(addr[22:20]);
      sel = 8'h01 << idx;
      if (dly >= 0 && dly <= TMO_A - 1) begin
         c_exp   = dly + 1;
         exp_rd  = eff_wr ? 32'h0 : rd;
         exp_err = serr;
      end else begin
         c_exp   = TMO_A;
         exp_rd  = 32'hDEADBEEF;
         exp_err = 1'b1;
      end
      @(posedge clk); #1;
      a_addr  = addr;
      a_wdata = wdata;
      a_wen   = eff_wr;
      a_ren   = !wr | both;
      @(posedge clk); #1;
      a_wen   = 1'b0;
      a_ren   = 1'b0;
      a_addr  = $urandom;
      a_wdata = $urandom;
      check_val("strobe_wen", 64'(a_m_wen), eff_wr ? 64'(sel) : 64'h0);
      check_val("strobe_ren", 64'(a_m_ren), eff_wr ? 64'h0 : 64'(sel));
      check_val("m_addr", 64'(a_m_addr), 64'(addr));
      check_val("m_wdata", 64'(a_m_wdata), 64'(wdata));
      n_ack    = 0;
      c_seen   = -1;
      n_stray  = 0;
      rd_seen  = 32'h0;
      err_seen = 1'b0;
      for (int c = 0; c <= TMO_A + 3; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         a_m_ack = 8'($urandom) & ~sel;
         a_m_err = 8'($urandom);
         for (int k = 0; k < 8; k++) a_m_rdata[32*k +: 32] = $urandom;
         if (c == dly) begin
            a_m_ack = a_m_ack | sel;
            a_m_err[idx] = serr;
            a_m_rdata[32*idx +: 32] = rd;
         end else if (c >= c_exp) begin
            a_m_ack = a_m_ack | (sel & 8'($urandom));
         end
         if (inject && c == dly) a_m_ack[2] = 1'b1;
         if (inject && c == 1) begin
            a_wen  = 1'b1;
            a_addr = 32'h0020_0000;
         end else begin
            a_wen  = 1'b0;
         end
         if (c > 0 && (a_m_wen | a_m_ren) != 8'h0) n_stray++;
         if (a_ack_o) begin
            n_ack++;
            if (c_seen < 0) begin
               c_seen   = c;
               rd_seen  = a_rdata_o;
               err_seen = a_err_o;
            end
         end else if (a_rdata_o != 32'h0 || a_err_o) begin
            n_stray++;
         end
      end
      a_m_ack = 8'h0;
      check_val("ack_count", 64'(n_ack), 64'd1);
      check_val("ack_cycle", 64'(c_seen), 64'(c_exp));
      check_val("rdata", 64'(rd_seen), 64'(exp_rd));
      check_val("err", 64'(err_seen), 64'(exp_err));
      check_val("stray_activity", 64'(n_stray), 64'd0);
   endtask

   initial begin
      int dly;
      int slv;
      bit wr;
      bit both;
      int r;
      int n_late;
      rstn = 1'b0;
      a_addr = '0; a_wdata = '0; a_wen = 1'b0; a_ren = 1'b0;
      a_m_rdata = '0; a_m_ack = '0; a_m_err = '0;
      b_addr = '0; b_wdata = '0; b_wen = 1'b0; b_ren = 1'b0;
      b_m_rdata = '0; b_m_ack = '0; b_m_err = '0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_ack", 64'(a_ack_o), 64'd0);
      check_val("rst_rdata", 64'(a_rdata_o), 64'd0);
      check_val("rst_strobes", 64'({a_m_wen, a_m_ren}), 64'd0);
      check_val("rst_m_addr", 64'(a_m_addr), 64'd0);
      check_val("rst_drop", 64'(a_drop), 64'd0);
      rstn = 1'b1;

      run_txn(1'b1, 1'b0, 32'h0030_0010, 32'hCAFE_0001, 0, 32'h0, 1'b0, 1'b0);
      run_txn(1'b0, 1'b0, 32'h0050_0000, 32'h0, 4, 32'h1234_5678, 1'b0, 1'b0);
      run_txn(1'b0, 1'b0, 32'h0010_0000, 32'h0, -1, 32'h0, 1'b0, 1'b0);
      run_txn(1'b0, 1'b0, 32'h0060_0008, 32'h0, TMO_A - 1, 32'hA5A5_0F0F, 1'b1, 1'b0);
      run_txn(1'b1, 1'b0, 32'h0020_0000, 32'h5, TMO_A, 32'h0, 1'b0, 1'b0);

      for (int t = 0; t < 40; t++) begin
         slv  = $urandom_range(0, 7);
         wr   = 1'($urandom_range(0, 1));
         both = ($urandom_range(0, 7) == 0);
         r    = $urandom_range(0, 9);
         if (r < 6)      dly = $urandom_range(0, 5);
         else if (r < 8) dly = $urandom_range(TMO_A - 2, TMO_A + 1);
         else            dly = -1;
         run_txn(wr, both, {$urandom_range(0, 255) & 32'hFF, 1'($urandom_range(0, 1)), 3'(slv), 20'($urandom)},
                 $urandom, dly, $urandom, 1'($urandom_range(0, 1)), 1'b0);
      end
      check_val("no_drop_yet", 64'(a_drop), 64'd0);

      run_txn(1'b0, 1'b0, 32'h0070_0004, 32'h0, 5, 32'h0BAD_F00D, 1'b0, 1'b1);
      check_val("drop_set", 64'(a_drop), 64'd1);

      // reset while waiting on slave 4, late ack must be ignored
      @(posedge clk); #1;
      a_addr = 32'h0040_0000; a_ren = 1'b1;
      @(posedge clk); #1;
      a_ren = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b0;
      @(posedge clk); #1;
      check_val("midrst_m_addr", 64'(a_m_addr), 64'd0);
      check_val("midrst_drop", 64'(a_drop), 64'd0);
      check_val("midrst_ack", 64'(a_ack_o), 64'd0);
      rstn = 1'b1;
      a_m_ack = 8'h10;
      n_late = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (a_ack_o) n_late++;
      end
      a_m_ack = 8'h0;
      check_val("late_ack_ignored", 64'(n_late), 64'd0);
      run_txn(1'b0, 1'b0, 32'h0040_0000, 32'h0, 2, 32'h7777_8888, 1'b0, 1'b0);

      // SN=6 instance: out-of-range slave index answers at T+1 with error
      @(posedge clk); #1;
      b_addr = 32'h0070_0000; b_wen = 1'b1; b_wdata = 32'h1;
      @(posedge clk); #1;
      b_wen = 1'b0;
      check_val("b_bad_ack", 64'(b_ack_o), 64'd1);
      check_val("b_bad_err", 64'(b_err_o), 64'd1);
      check_val("b_bad_rdata", 64'(b_rdata_o), 64'hDEAD_BEEF);
      check_val("b_bad_strobe", 64'({b_m_wen, b_m_ren}), 64'd0);
      @(posedge clk); #1;
      check_val("b_bad_ack_end", 64'(b_ack_o), 64'd0);
      check_val("b_bad_rdata_end", 64'(b_rdata_o), 64'd0);
      b_addr = 32'h0050_0000; b_ren = 1'b1;
      @(posedge clk); #1;
      b_ren = 1'b0;
      check_val("b_ren5", 64'(b_m_ren), 64'h20);
      b_m_ack = 6'h20;
      b_m_rdata[32*5 +: 32] = 32'h0605_0403;
      @(posedge clk); #1;
      b_m_ack = 6'h0;
      check_val("b_ok_ack", 64'(b_ack_o), 64'd1);
      check_val("b_ok_rdata", 64'(b_rdata_o), 64'h0605_0403);
      check_val("b_ok_err", 64'(b_err_o), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
